// File: rtl/lisnoc_flit_buffer_pkg.sv
// Shared lisnoc flit definitions: type field width, type encodings and
// the packet-boundary test used by buffers, sources, sinks and routers.
package lisnoc_flit_buffer_pkg;

  localparam int FLIT_TYPE_WIDTH = 2;

  typedef enum logic [FLIT_TYPE_WIDTH-1:0] {
    FLIT_TYPE_PAYLOAD = 2'b00,
    FLIT_TYPE_HEAD    = 2'b01,
    FLIT_TYPE_TAIL    = 2'b10,
    FLIT_TYPE_SINGLE  = 2'b11
  } flit_type_e;

  // Tail and single flits close a packet.
  function automatic logic flit_ends_packet(input logic [FLIT_TYPE_WIDTH-1:0] flit_type);
    return (flit_type == FLIT_TYPE_TAIL) || (flit_type == FLIT_TYPE_SINGLE);
  endfunction

endpackage

// File: rtl/lisnoc_flit_buffer.sv
// First-word-fall-through flit buffer with optional store-and-forward by packet.
// Outputs depend only on registered state.
module lisnoc_flit_buffer
  import lisnoc_flit_buffer_pkg::*;
#(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEPTH           = 4,
  parameter int PACKET_MODE     = 0,
  localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
  localparam int CNT_WIDTH      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  fill,
  output logic [CNT_WIDTH-1:0]  packets
);

  localparam int                   PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  fill_q;
  logic [CNT_WIDTH-1:0]  packets_q;
  logic                  draining_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic in_end;
  logic out_end;

  assign full     = (fill_q == FULL_CNT);
  assign empty    = (fill_q == '0);
  assign in_ready = !full;
  assign out_flit = mem[rd_ptr];
  assign fill     = fill_q;
  assign packets  = packets_q;

  // Store-and-forward holds a partial packet back unless it can never
  // complete in place (buffer full) or an oversize packet is already streaming.
  assign out_valid = (PACKET_MODE == 0) ? !empty
                   : (!empty && ((packets_q != '0) || full || draining_q));

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign in_end  = flit_ends_packet(in_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH]);
  assign out_end = flit_ends_packet(out_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH]);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_q     <= '0;
      packets_q  <= '0;
      draining_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);
      end

      case ({push, pop})
        2'b10:   fill_q <= fill_q + CNT_WIDTH'(1);
        2'b01:   fill_q <= fill_q - CNT_WIDTH'(1);
        default: fill_q <= fill_q;
      endcase

      case ({push && in_end, pop && out_end})
        2'b10:   packets_q <= packets_q + CNT_WIDTH'(1);
        2'b01:   packets_q <= packets_q - CNT_WIDTH'(1);
        default: packets_q <= packets_q;
      endcase

      // Closing the oversize packet takes priority over re-arming on a full pop.
      if (PACKET_MODE != 0 && pop) begin
        if (out_end) begin
          draining_q <= 1'b0;
        end else if (full) begin
          draining_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lisnoc_flit_buffer.sv
// Directed bench for lisnoc_flit_buffer: cut-through, store-and-forward and
// non-power-of-two instances checked against a queue-based reference model.
module tb_lisnoc_flit_buffer;
  import lisnoc_flit_buffer_pkg::*;

  localparam int FW = 34;

  logic          clk;
  logic          rst;
  logic [FW-1:0] in_flit_a   [3];
  logic          in_valid_a  [3];
  logic          in_ready_a  [3];
  logic [FW-1:0] out_flit_a  [3];
  logic          out_valid_a [3];
  logic          out_ready_a [3];
  logic [2:0]    fill_a      [3];
  logic [2:0]    packets_a   [3];
  logic [1:0]    fill_d3;
  logic [1:0]    packets_d3;

  assign fill_a[2]    = {1'b0, fill_d3};
  assign packets_a[2] = {1'b0, packets_d3};

  lisnoc_flit_buffer #(.FLIT_DATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(0)) u_m0 (
    .clk(clk), .rst(rst),
    .in_flit(in_flit_a[0]), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .out_flit(out_flit_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .fill(fill_a[0]), .packets(packets_a[0]));

  lisnoc_flit_buffer #(.FLIT_DATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(1)) u_m1 (
    .clk(clk), .rst(rst),
    .in_flit(in_flit_a[1]), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .out_flit(out_flit_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .fill(fill_a[1]), .packets(packets_a[1]));

  lisnoc_flit_buffer #(.FLIT_DATA_WIDTH(32), .DEPTH(3), .PACKET_MODE(0)) u_d3 (
    .clk(clk), .rst(rst),
    .in_flit(in_flit_a[2]), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .out_flit(out_flit_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
    .fill(fill_d3), .packets(packets_d3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model for the selected instance.
  int            sel;
  int            depth_m;
  int            mode_m;
  logic          drain_m;
  logic [FW-1:0] sb [$];

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  function automatic int count_ends();
    int n = 0;
    foreach (sb[i]) if (sb[i][FW-1:FW-2] inside {2'b10, 2'b11}) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %0h expected %0h", tag, sel, obs, exp);
    end
  endtask

  // One cycle: drive at the negedge, check settled outputs, advance the model.
  task automatic cyc(input logic iv, input logic [FW-1:0] fl, input logic ordy, output logic acc);
    logic exp_full, exp_ov, pop_now;
    logic [FW-1:0] head;
    in_valid_a[sel]  = iv;
    in_flit_a[sel]   = fl;
    out_ready_a[sel] = ordy;
    #1;
    exp_full = (sb.size() == depth_m);
    exp_ov   = (sb.size() != 0) && (mode_m == 0 || count_ends() != 0 || exp_full || drain_m);
    chk("fill", FW'(fill_a[sel]), FW'(sb.size()));
    chk("packets", FW'(packets_a[sel]), FW'(count_ends()));
    chk("in_ready", FW'(in_ready_a[sel]), FW'(!exp_full));
    chk("out_valid", FW'(out_valid_a[sel]), FW'(exp_ov));
    if (exp_ov) chk("out_flit", out_flit_a[sel], sb[0]);
    acc     = iv && !exp_full;
    pop_now = exp_ov && ordy;
    if (pop_now) begin
      head = sb.pop_front();
      if (head[FW-1:FW-2] inside {2'b10, 2'b11}) drain_m = 1'b0;
      else if (exp_full && mode_m != 0)          drain_m = 1'b1;
    end
    if (acc) sb.push_back(fl);
    @(negedge clk);
  endtask

  task automatic send(input logic [FW-1:0] fl, input logic ordy);
    logic acc = 1'b0;
    int   n   = 0;
    while (!acc && n < 50) begin
      cyc(1'b1, fl, ordy, acc);
      n++;
    end
    if (!acc) begin
      errors++;
      $error("FAIL send_timeout dut%0d observed not-accepted expected accepted", sel);
    end
  endtask

  task automatic drain();
    logic acc;
    int   n = 0;
    while (sb.size() != 0 && n < 50) begin
      cyc(1'b0, '0, 1'b1, acc);
      n++;
    end
    if (sb.size() != 0) begin
      errors++;
      $error("FAIL drain_timeout dut%0d observed %0d left expected 0", sel, sb.size());
    end
    cyc(1'b0, '0, 1'b0, acc);
  endtask

  task automatic select(input int s, input int d, input int m);
    sel = s; depth_m = d; mode_m = m; drain_m = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic acc;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i] = 1'b0; in_flit_a[i] = '0; out_ready_a[i] = 1'b0;
    end
    rst = 1'b1;
    select(0, 4, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Cut-through: head then tail with sink always ready.
    cyc(1'b0, '0, 1'b0, acc);
    send(mk(FLIT_TYPE_HEAD, 32'h0123_4567), 1'b1);
    send(mk(FLIT_TYPE_TAIL, 32'hdead_beef), 1'b1);
    drain();

    // Cut-through: fill to DEPTH with the sink stalled, then release.
    for (int i = 0; i < 4; i++) send(mk(FLIT_TYPE_SINGLE, 32'h100 + i), 1'b0);
    cyc(1'b1, mk(FLIT_TYPE_SINGLE, 32'h104), 1'b0, acc);
    send(mk(FLIT_TYPE_SINGLE, 32'h104), 1'b1);
    drain();

    // Store-and-forward: three-flit packet held until its tail arrives.
    select(1, 4, 1);
    cyc(1'b0, '0, 1'b1, acc);
    send(mk(FLIT_TYPE_HEAD, 32'h200), 1'b1);
    send(mk(FLIT_TYPE_PAYLOAD, 32'h201), 1'b1);
    send(mk(FLIT_TYPE_TAIL, 32'h202), 1'b1);
    drain();

    // Store-and-forward: six-flit packet forces the full-buffer drain path.
    send(mk(FLIT_TYPE_HEAD, 32'h300), 1'b1);
    for (int i = 1; i <= 4; i++) send(mk(FLIT_TYPE_PAYLOAD, 32'h300 + i), 1'b1);
    send(mk(FLIT_TYPE_TAIL, 32'h305), 1'b1);
    drain();
    // Draining must be clear again: a lone head is held back.
    send(mk(FLIT_TYPE_HEAD, 32'h310), 1'b1);
    cyc(1'b0, '0, 1'b1, acc);
    cyc(1'b0, '0, 1'b1, acc);
    send(mk(FLIT_TYPE_TAIL, 32'h311), 1'b1);
    drain();

    // DEPTH=3: pointer wrap under random sink stalls.
    select(2, 3, 0);
    cyc(1'b0, '0, 1'b0, acc);
    for (int i = 0; i < 10; i++) begin
      acc = 1'b0;
      for (int n = 0; n < 50 && !acc; n++)
        cyc(1'b1, mk(FLIT_TYPE_SINGLE, 32'h400 + i), 1'($urandom_range(0, 1)), acc);
      if (!acc) begin
        errors++;
        $error("FAIL wrap_send_timeout observed not-accepted expected accepted");
      end
    end
    drain();

    // Reset with two flits stored while both handshakes are asserted.
    select(0, 4, 0);
    send(mk(FLIT_TYPE_SINGLE, 32'h500), 1'b0);
    send(mk(FLIT_TYPE_SINGLE, 32'h501), 1'b0);
    cyc(1'b0, '0, 1'b0, acc);
    rst = 1'b1;
    in_valid_a[0] = 1'b1; in_flit_a[0] = mk(FLIT_TYPE_SINGLE, 32'h502); out_ready_a[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    drain_m = 1'b0;
    cyc(1'b0, '0, 1'b1, acc);
    chk("rst_fill", FW'(fill_a[0]), FW'(0));
    chk("rst_out_valid", FW'(out_valid_a[0]), FW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
